// File: rtl/spi_slave_pkg.sv
// Shared types and encodings for the SPI-to-RAM slave front-end.
package spi_slave_pkg;

   // Slave FSM states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHK_CMD,
      ST_WRITE,
      ST_READ_ADD,
      ST_READ_DATA,
      ST_WAIT_TX,
      ST_TX,
      ST_DONE
   } state_e;

   // Command prefixes (CMD_W = 2); MSB selects write(0)/read(1)
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   // States in which SS_n rising is treated as an aborted frame
   function automatic logic in_frame(input state_e s);
      return s inside {ST_CHK_CMD, ST_WRITE, ST_READ_ADD, ST_READ_DATA, ST_WAIT_TX, ST_TX};
   endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parallel-load shift register, MSB-first, with bit down-counter and last flag.
module spi_shift_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift_en,
   input  logic             ser_in,
   output logic [WIDTH-1:0] word_c,
   output logic             msb,
   output logic             last_c
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] data_q;
   logic [CNT_W-1:0] cnt_q;

   // Load reloads the counter; shift moves one bit toward the MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= CNT_W'(WIDTH - 1);
      end else if (load) begin
         data_q <= load_data;
         cnt_q  <= CNT_W'(WIDTH - 1);
      end else if (shift_en) begin
         data_q <= word_c;
         cnt_q  <= cnt_q - CNT_W'(1);
      end
   end

   assign word_c = {data_q[WIDTH-2:0], ser_in};
   assign msb    = data_q[WIDTH-1];
   assign last_c = (cnt_q == '0);

endmodule

// File: rtl/spi_slave_cfg.sv
// SPI slave front-end: deserialises command words, serialises read data on MISO.
module spi_slave_cfg
   import spi_slave_pkg::*;
#(
   parameter  int unsigned DATA_W = 8,
   parameter  int unsigned CMD_W  = 2,
   localparam int unsigned RX_W   = CMD_W + DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [RX_W-1:0]   rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              frame_err,
   output logic              busy
);

   state_e state_q;
   logic   rd_pending_q;

   logic              abort_c;
   logic              in_data_c;
   logic              rx_load_c;
   logic              rx_shift_c;
   logic              tx_load_c;
   logic              tx_shift_c;
   logic [DATA_W-1:0] tx_load_data_c;

   logic [RX_W-1:0]   rx_word_c;
   logic              rx_last_c;
   logic              rx_msb_unused;
   logic [DATA_W-1:0] tx_word_unused;
   logic              tx_last_c;

   // Shift-register controls derived from the current state and pins
   always_comb begin
      abort_c        = SS_n && in_frame(state_q);
      in_data_c      = state_q inside {ST_WRITE, ST_READ_ADD, ST_READ_DATA};
      rx_load_c      = 1'b0;
      rx_shift_c     = 1'b0;
      tx_load_c      = 1'b0;
      tx_shift_c     = 1'b0;
      tx_load_data_c = '0;

      if (abort_c || state_q == ST_IDLE) begin
         rx_load_c = 1'b1;
      end else if (state_q == ST_CHK_CMD) begin
         rx_shift_c = 1'b1;
      end else if (in_data_c) begin
         if (rx_last_c) rx_load_c  = 1'b1;
         else           rx_shift_c = 1'b1;
      end

      // The TX register MSB drives MISO, so it is cleared whenever TX ends
      if (abort_c) begin
         tx_load_c = 1'b1;
      end else if (state_q == ST_WAIT_TX && tx_valid) begin
         tx_load_c      = 1'b1;
         tx_load_data_c = tx_data;
      end else if (state_q == ST_TX) begin
         if (tx_last_c) tx_load_c  = 1'b1;
         else           tx_shift_c = 1'b1;
      end
   end

   // Receive deserialiser: command bit plus remaining RX_W-1 bits
   spi_shift_reg #(.WIDTH(RX_W)) u_rx_sr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (rx_load_c),
      .load_data ('0),
      .shift_en  (rx_shift_c),
      .ser_in    (MOSI),
      .word_c    (rx_word_c),
      .msb       (rx_msb_unused),
      .last_c    (rx_last_c)
   );

   // Transmit serialiser: MSB is the registered MISO bit
   spi_shift_reg #(.WIDTH(DATA_W)) u_tx_sr (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (tx_load_c),
      .load_data (tx_load_data_c),
      .shift_en  (tx_shift_c),
      .ser_in    (1'b0),
      .word_c    (tx_word_unused),
      .msb       (MISO),
      .last_c    (tx_last_c)
   );

   // Frame FSM with registered status and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         rd_pending_q <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (abort_c) begin
            state_q   <= ST_IDLE;
            frame_err <= 1'b1;
            busy      <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (!SS_n) begin
                     state_q <= ST_CHK_CMD;
                     busy    <= 1'b1;
                  end
               end
               ST_CHK_CMD: begin
                  if (!MOSI)             state_q <= ST_WRITE;
                  else if (rd_pending_q) state_q <= ST_READ_DATA;
                  else                   state_q <= ST_READ_ADD;
               end
               ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                  if (rx_last_c) begin
                     rx_data  <= rx_word_c;
                     rx_valid <= 1'b1;
                     if (state_q == ST_READ_DATA) begin
                        state_q <= ST_WAIT_TX;
                     end else begin
                        state_q <= ST_DONE;
                        if (state_q == ST_READ_ADD) rd_pending_q <= 1'b1;
                     end
                  end
               end
               ST_WAIT_TX: begin
                  if (tx_valid) state_q <= ST_TX;
               end
               ST_TX: begin
                  if (tx_last_c) begin
                     rd_pending_q <= 1'b0;
                     state_q      <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  if (SS_n) begin
                     state_q <= ST_IDLE;
                     busy    <= 1'b0;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
